// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Result codes are one-hot {greater, less, equal} so consumers can decode directly.
package seq_cmp_pkg;

    typedef enum logic {
        IDLE,
        CMP
    } state_e;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    // Slice index counter width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_mag_comparator_cmp_chunk_slice.sv
// Combinational CHUNK-bit unsigned compare; flip_msb biases the top bit so a
// two's-complement slice compares correctly as unsigned.
module cmp_chunk_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             flip_msb,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] mask;
    logic [CHUNK-1:0] a_adj;
    logic [CHUNK-1:0] b_adj;

    always_comb begin
        mask            = '0;
        mask[CHUNK-1]   = flip_msb;
        a_adj           = a ^ mask;
        b_adj           = b ^ mask;
        gt              = (a_adj > b_adj);
        lt              = (a_adj < b_adj);
        eq              = (a_adj == b_adj);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices MSB-first and stops
// at the first differing slice, reporting the result with a one-cycle done pulse.
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             less,
    output logic             equal,
    output logic             early_exit
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_width
        $error("seq_mag_comparator: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        res_q, res_d;
    logic              early_q, early_d;

    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic              slice_gt, slice_lt, slice_eq;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_slice = a_q[i*CHUNK +: CHUNK];
                b_slice = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    cmp_chunk_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a        (a_slice),
        .b        (b_slice),
        .flip_msb (sgn_q && (idx_q == TOP_IDX)),
        .gt       (slice_gt),
        .lt       (slice_lt),
        .eq       (slice_eq)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        early_d = early_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = ain;
                    b_d     = bin;
                    sgn_d   = signed_mode;
                    idx_d   = TOP_IDX;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!slice_eq) begin
                    res_d   = slice_gt ? GT : LT;
                    early_d = (idx_q != '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    res_d   = EQ;
                    early_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            early_q <= early_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign greater    = res_q[2];
    assign less       = res_q[1];
    assign equal      = res_q[0];
    assign early_exit = early_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator (WIDTH=32, CHUNK=8): vector table plus
// hand-written handshake and reset sequences.
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] ain;
    logic [31:0] bin;
    logic        busy, done, greater, less, equal, early_exit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        eg;
        logic        el;
        logic        ee;
        logic        eearly;
        int          elat;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    seq_mag_comparator #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .ain         (ain),
        .bin         (bin),
        .busy        (busy),
        .done        (done),
        .greater     (greater),
        .less        (less),
        .equal       (equal),
        .early_exit  (early_exit)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, " busy"}, {31'd0, busy}, 32'd0);
        chk({name, " done"}, {31'd0, done}, 32'd0);
        chk({name, " flags"}, {28'd0, greater, less, equal, early_exit}, 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        start       = 1'b1;
        ain         = a;
        bin         = b;
        signed_mode = s;
    endtask

    // Consumes the accepting edge, then counts cycles until done. A spurious
    // start with flipped operands is injected after 'inject' cycles if >= 0.
    task automatic wait_result(input string name, input logic eg, input logic el,
                               input logic ee, input logic eearly,
                               input int elat, input int inject);
        int lat;
        bit got;
        @(posedge clk); #1;
        chk({name, " accept busy"}, {31'd0, busy}, 32'd1);
        chk({name, " accept done"}, {31'd0, done}, 32'd0);
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 16) begin
            if (lat == inject) begin
                start       = 1'b1;
                ain         = ~ain;
                bin         = ~bin;
                signed_mode = ~signed_mode;
            end
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (done) got = 1'b1;
            else chk({name, " busy mid"}, {31'd0, busy}, 32'd1);
        end
        chk({name, " done seen"}, {31'd0, got}, 32'd1);
        chk({name, " latency"}, lat, elat);
        chk({name, " busy at done"}, {31'd0, busy}, 32'd0);
        chk({name, " flags"}, {28'd0, greater, less, equal, early_exit},
            {28'd0, eg, el, ee, eearly});
    endtask

    initial begin
        vecs[0] = '{"u_last_slice", 32'h12345678, 32'h12345677, 1'b0, 1, 0, 0, 0, 4};
        vecs[1] = '{"u_msb",        32'h80000000, 32'h00000001, 1'b0, 1, 0, 0, 1, 1};
        vecs[2] = '{"s_msb",        32'h80000000, 32'h00000001, 1'b1, 0, 1, 0, 1, 1};
        vecs[3] = '{"equal",        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0, 0, 1, 0, 4};
        vecs[4] = '{"u_slice2",     32'h00010000, 32'h00020000, 1'b0, 0, 1, 0, 1, 2};
        vecs[5] = '{"s_neg1_zero",  32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 1, 0, 1, 1};
        vecs[6] = '{"s_low_unsig",  32'hFFFFFF00, 32'hFFFFFF80, 1'b1, 0, 1, 0, 0, 4};
        vecs[7] = '{"s_max_min",    32'h7FFFFFFF, 32'h80000000, 1'b1, 1, 0, 0, 1, 1};
        vecs[8] = '{"u_slice1",     32'h00000100, 32'h00000000, 1'b0, 1, 0, 0, 1, 3};

        // Reset held with random inputs, including start.
        rst_n       = 1'b0;
        start       = 1'($urandom);
        signed_mode = 1'($urandom);
        ain         = $urandom;
        bin         = $urandom;
        repeat (3) @(posedge clk);
        #1 chk_idle_zero("reset");
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_idle_zero("post_reset");

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, vecs[i].sgn);
            wait_result(vecs[i].name, vecs[i].eg, vecs[i].el, vecs[i].ee,
                        vecs[i].eearly, vecs[i].elat, -1);
        end

        // Start mid-compare with changed operands must be ignored.
        @(negedge clk);
        issue(32'h11223344, 32'h11223355, 1'b0);
        wait_result("ignored_start", 0, 1, 0, 0, 4, 1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("ignored_start no_extra_done", {31'd0, done}, 32'd0);
            chk("ignored_start stays_idle", {31'd0, busy}, 32'd0);
        end

        // Back-to-back: start raised during the done cycle.
        @(negedge clk);
        issue(32'h00000005, 32'h00000009, 1'b0);
        wait_result("b2b_first", 0, 1, 0, 0, 4, -1);
        issue(32'hF0000000, 32'h10000000, 1'b1);
        wait_result("b2b_second", 0, 1, 0, 1, 1, -1);

        // Reset pulse in cycle 2 of an equal-operand compare.
        @(negedge clk);
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_idle_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk_idle_zero("after_mid_reset");
        end
        @(negedge clk);
        issue(32'h00000001, 32'h00000002, 1'b0);
        wait_result("after_reset_run", 0, 1, 0, 0, 4, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
